// File: rtl/fifo_wr_arbiter.sv
// Round-robin packet arbiter for an async FIFO write port: grants one source
// for a full packet, streams its words, and stalls combinationally on full.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int PKT_SIZE   = 10
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] src_data_i,
  input  logic                          full_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            data_ack_o,
  output logic                          w_inc_o,
  output logic [DATA_WIDTH-1:0]         wr_data_o,
  output logic                          busy_o,
  output logic                          pkt_done_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(PKT_SIZE);

  typedef enum logic {IDLE, XFER} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pkt_done_q, pkt_done_d;
  logic [IDX_W-1:0]   win_idx;
  logic               w_inc;

  // Winner search starts one past the last grant and wraps.
  always_comb begin : arb
    logic [IDX_W-1:0] idx;
    logic             found;
    win_idx = last_q;
    idx     = '0;
    found   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'((int'(last_q) + k) % NUM_REQ);
      if (!found && req_i[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
  end

  assign w_inc = (state_q == XFER) && !full_i;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    pkt_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          last_d         = win_idx;
          cnt_d          = '0;
          state_d        = XFER;
        end
      end
      XFER: begin
        if (w_inc) begin
          if (cnt_q == CNT_W'(PKT_SIZE - 1)) begin
            state_d    = IDLE;
            gnt_d      = '0;
            cnt_d      = '0;
            pkt_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      last_q     <= IDX_W'(NUM_REQ - 1);
      cnt_q      <= '0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  // One-hot grant selects the write word; an empty grant yields zero.
  always_comb begin
    wr_data_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) wr_data_o = src_data_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign gnt_o      = gnt_q;
  assign data_ack_o = gnt_q & {NUM_REQ{w_inc}};
  assign w_inc_o    = w_inc;
  assign busy_o     = (state_q == XFER);
  assign pkt_done_o = pkt_done_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-packet vector table plus hand
// sequences for reset, request withdrawal and mid-packet reset.
module tb_fifo_wr_arbiter;

  localparam int DW  = 8;
  localparam int NR  = 4;
  localparam int PKT = 10;
  localparam logic [7:0] BASE [4] = '{8'h10, 8'h40, 8'hA0, 8'hD0};

  logic          clk;
  logic          rst_n;
  logic [NR-1:0] req;
  logic [NR*DW-1:0] src_data;
  logic          full;
  logic [NR-1:0] gnt, ack;
  logic          w_inc, busy, done;
  logic [DW-1:0] wr_data;

  logic [7:0]    ptr [4];
  logic [NR-1:0] ack_smp = '0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] exp_gnt;
    int         src;
    int         stall_at;
    int         stall_len;
    int         drop_at;
    logic [3:0] req_drop;
    logic       prev_done;
  } vec_t;

  vec_t tbl [8];

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .PKT_SIZE(PKT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .src_data_i(src_data),
    .full_i(full), .gnt_o(gnt), .data_ack_o(ack), .w_inc_o(w_inc),
    .wr_data_o(wr_data), .busy_o(busy), .pkt_done_o(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source model: each source steps to its next word when acknowledged.
  always @(negedge clk) ack_smp <= ack;
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) ptr[i] <= 8'd0;
      else if (ack_smp[i]) ptr[i] <= (ptr[i] == 8'd9) ? 8'd0 : ptr[i] + 8'd1;
    end
  end
  always_comb begin
    src_data = '0;
    for (int i = 0; i < 4; i++) src_data[i*DW +: DW] = BASE[i] + ptr[i];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic r_n, input logic [3:0] r, input logic f);
    @(posedge clk);
    #1;
    rst_n = r_n;
    req   = r;
    full  = f;
    @(negedge clk);
  endtask

  task automatic chk_idle(input string nm, input logic exp_done);
    chk({nm, "_gnt"},   32'(gnt), 32'd0);
    chk({nm, "_busy"},  32'(busy), 32'd0);
    chk({nm, "_winc"},  32'(w_inc), 32'd0);
    chk({nm, "_ack"},   32'(ack), 32'd0);
    chk({nm, "_wdata"}, 32'(wr_data), 32'd0);
    chk({nm, "_done"},  32'(done), 32'(exp_done));
  endtask

  task automatic run_pkt(input int id, input vec_t v);
    int w, xc, st;
    logic f;
    logic [3:0] r;
    step(1'b1, v.req, 1'b0);
    chk_idle($sformatf("v%0d_arb", id), v.prev_done);
    w = 0; xc = 0; st = 0;
    while (w < PKT && xc < 40) begin
      f = (w == v.stall_at) && (st < v.stall_len);
      r = (w >= v.drop_at) ? v.req_drop : v.req;
      step(1'b1, r, f);
      xc++;
      chk($sformatf("v%0d_gnt", id),   32'(gnt), 32'(v.exp_gnt));
      chk($sformatf("v%0d_busy", id),  32'(busy), 32'd1);
      chk($sformatf("v%0d_winc", id),  32'(w_inc), 32'(!f));
      chk($sformatf("v%0d_ack", id),   32'(ack), f ? 32'd0 : 32'(v.exp_gnt));
      chk($sformatf("v%0d_wdata%0d", id, w), 32'(wr_data), 32'(8'(BASE[v.src] + 8'(w))));
      chk($sformatf("v%0d_done", id),  32'(done), 32'd0);
      if (f) st++;
      else w++;
    end
    chk($sformatf("v%0d_xfer_cycles", id), 32'(xc), 32'(PKT + v.stall_len));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    full  = 1'b0;

    //          req      gnt      src stall_at len drop_at req_drop prev_done
    tbl[0] = '{4'b1111, 4'b0001, 0,  99,      0,  99,     4'b1111, 1'b0};
    tbl[1] = '{4'b1111, 4'b0010, 1,  99,      0,  99,     4'b1111, 1'b1};
    tbl[2] = '{4'b1111, 4'b0100, 2,  99,      0,  99,     4'b1111, 1'b1};
    tbl[3] = '{4'b1111, 4'b1000, 3,  99,      0,  99,     4'b1111, 1'b1};
    tbl[4] = '{4'b1111, 4'b0001, 0,  99,      0,  99,     4'b1111, 1'b1};
    tbl[5] = '{4'b0100, 4'b0100, 2,  99,      0,  99,     4'b0100, 1'b1};
    tbl[6] = '{4'b0100, 4'b0100, 2,  4,       3,  99,     4'b0100, 1'b1};
    tbl[7] = '{4'b0010, 4'b0010, 1,  99,      0,  2,      4'b0000, 1'b1};

    // Reset held with all sources requesting.
    step(1'b0, 4'b1111, 1'b0);
    chk_idle("rst1", 1'b0);
    step(1'b0, 4'b1111, 1'b0);
    chk_idle("rst2", 1'b0);

    for (int i = 0; i < 8; i++) run_pkt(i, tbl[i]);

    // Withdrawn request: packet completed, then no new grant.
    step(1'b1, 4'b0000, 1'b0);
    chk_idle("wd_done", 1'b1);
    step(1'b1, 4'b0000, 1'b0);
    chk_idle("wd_idle", 1'b0);

    // Source 3 packet abandoned by reset after its 6th write.
    step(1'b1, 4'b1000, 1'b0);
    chk_idle("mr_arb", 1'b0);
    for (int w = 0; w < 6; w++) begin
      step(1'b1, 4'b1000, 1'b0);
      chk($sformatf("mr_gnt%0d", w),   32'(gnt), 32'b1000);
      chk($sformatf("mr_winc%0d", w),  32'(w_inc), 32'd1);
      chk($sformatf("mr_wdata%0d", w), 32'(wr_data), 32'(8'(BASE[3] + 8'(w))));
    end
    step(1'b0, 4'b1001, 1'b0);
    run_pkt(8, '{4'b1001, 4'b0001, 0, 99, 0, 99, 4'b1001, 1'b0});
    step(1'b1, 4'b0000, 1'b0);
    chk_idle("end_done", 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin packet arbiter that shares the asynchronous FIFO's write port among `NUM_REQ` byte-stream sources. It sits in the write-clock domain in front of the FIFO. It grants one source at a time for a whole packet of `PKT_SIZE` words and drives `W_INC`/`WR_DATA`, stalling on `FULL`. A granted packet is never interleaved with another source's data.

## Interface
- `DATA_WIDTH`, 8: width of each data word.
- `NUM_REQ`, 4: number of requesters (2..8).
- `PKT_SIZE`, 10: words per packet (≥2).
- `CLK`  in  1  write-domain clock, rising edge.
- `RST`  in  1  synchronous, active-low reset.
- `REQ`  in  `NUM_REQ`  per-source request; source i has a packet ready.
- `SRC_DATA`  in  `NUM_REQ*DATA_WIDTH`  flattened source words; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `FULL`  in  1  FIFO full flag, write-domain synchronized.
- `GNT`  out  `NUM_REQ`  one-hot grant, registered; all zero when idle.
- `DATA_ACK`  out  `NUM_REQ`  one-hot; the granted source's current word is consumed this cycle, and the source advances to its next word.
- `W_INC`  out  1  FIFO write enable.
- `WR_DATA`  out  `DATA_WIDTH`  FIFO write data.
- `BUSY`  out  1  high while a packet is in transfer.
- `PKT_DONE`  out  1  registered one-cycle pulse after a packet's last word is written.

## Operation
- States:
  - IDLE: `GNT` = 0. If `REQ` != 0 at the clock edge, the winner is chosen and loaded into `GNT`, `LAST` is set to the winner, the word counter is cleared, and the state goes to XFER. If `REQ` = 0, the state stays IDLE.
  - XFER: transfer in progress; `BUSY` = 1.
- Round-robin arbitration:
  - Priority search starts at (`LAST`+1) mod `NUM_REQ` and proceeds upward with wrap.
  - `LAST` resets to `NUM_REQ`-1, so source 0 has first priority after reset.
- Write path:
  - `W_INC` = (state==XFER) && !`FULL`. It is combinational on `FULL` so that no write occurs into a full FIFO.
  - `WR_DATA` = `SRC_DATA` slice selected by the registered `GNT`. It is 0 when idle.
  - `DATA_ACK` = `GNT` & {`NUM_REQ`{`W_INC`}}.
- Word counter:
  - Width is $clog2(`PKT_SIZE`).
  - Increments on each `W_INC`.
  - When `W_INC` occurs with count == `PKT_SIZE`-1: the state returns to IDLE, `GNT` clears, and `PKT_DONE` is 1 for the next cycle.
- Boundary conditions:
  - `REQ` changes during XFER are ignored. A granted packet always completes with exactly `PKT_SIZE` writes, even if its `REQ` drops.
  - `FULL` high in XFER: no write, no ack, counter holds, grant holds. There is no timeout.
  - `FULL` high on the last word: completion is deferred until the write actually occurs.
  - A single requester holding `REQ` is re-granted after one IDLE cycle.
  - Reset mid-packet: at the edge where `RST`=0, state→IDLE, counter=0, `LAST`=`NUM_REQ`-1. The partial packet is abandoned (already-written words remain in the FIFO).
- Reset value of every output is 0: `GNT`, `DATA_ACK`, `W_INC`, `WR_DATA`, `BUSY`, `PKT_DONE`.

## Timing
- `REQ` sampled at edge k (IDLE) → `GNT`/`BUSY` high from k, and the first `W_INC` occurs in cycle k..k+1 if `FULL`=0.
- Unstalled packet: `PKT_SIZE` consecutive `W_INC` cycles, then `GNT`=0 and `PKT_DONE`=1 in the following cycle.
- Back-to-back throughput is `PKT_SIZE`+1 cycles per packet, because of one mandatory IDLE arbitration cycle.
- Stall cost: each `FULL`-high cycle in XFER adds exactly one cycle.
- `FULL` → `W_INC` path is combinational; no registered lag.

## Test plan
- Reset: hold `RST`=0 for 2 cycles with `REQ`=4'b1111 → all outputs 0, no `W_INC`. After release, the first grant is 4'b0001.
- Single source: `REQ`=4'b0100, `FULL`=0, source 2 presents bytes 0xA0..0xA9 → `GNT`=4'b0100, then 10 consecutive `W_INC` with `WR_DATA` 0xA0..0xA9 and `DATA_ACK`=4'b0100 each cycle. `PKT_DONE` pulses once, then `BUSY`=0.
- Fairness: `REQ`=4'b1111 held → grant order 0001, 0010, 0100, 1000, 0001. Each grant has 10 writes, with an 11-cycle period per grant.
- Back-pressure: single source, `FULL`=1 for 3 cycles after the 4th write → `W_INC`/`DATA_ACK` low for those 3 cycles, `GNT` held, words 5–10 follow without loss. XFER lasts 13 cycles.
- Request withdrawal: `REQ`=4'b0010 dropped after the 2nd write → all 10 writes still occur, then IDLE.
- Reset mid-packet: `RST`=0 after the 6th write of source 3 → IDLE with outputs 0 next cycle. With `REQ`=4'b1001, the next grant is 4'b0001.
